// File: rtl/uart_tx_param_if.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_param_if
// Producer-side handshake and serial line of the parametrised UART transmitter.
// Rev    : 1.0
// ============================================================================
interface uart_tx_param_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] data;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    output start,
    output data,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  data,
    output tx,
    output busy,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_param
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Rev    : 1.0
// ============================================================================
module uart_tx_param #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_param_if.slave bus
);

  localparam int TIMER_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W   = $clog2(DATA_W + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DATA_W - 1);
  localparam logic               STOP_LAST  = 1'(STOP_BITS - 1);
  localparam logic               ODD_BIT    = 1'(PARITY_ODD);

  generate
    if (DATA_W < 5 || DATA_W > 9 || CLK_DIV < 2 ||
        (PARITY_EN != 0 && PARITY_EN != 1) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1) ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
      $error("uart_tx_param: unsupported parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [TIMER_W-1:0]  timer, timer_n;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0]   shift, shift_n;
  logic                par, par_n;
  logic                stop_cnt, stop_cnt_n;
  logic                done_r, done_n;
  logic                bit_end;
  logic                tx_d;

  assign bit_end = (timer == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      stop_cnt <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      par      <= par_n;
      stop_cnt <= stop_cnt_n;
      done_r   <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    timer_n    = bit_end ? '0 : timer + TIMER_W'(1);
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    par_n      = par;
    stop_cnt_n = stop_cnt;
    done_n     = 1'b0;
    case (state)
      S_IDLE: begin
        timer_n = '0;
        // Capture word and parity together so later data changes are harmless.
        if (bus.start) begin
          state_n    = S_START;
          shift_n    = bus.data;
          par_n      = (^bus.data) ^ ODD_BIT;
          bit_cnt_n  = '0;
          stop_cnt_n = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) state_n = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_n   = shift >> 1;
          bit_cnt_n = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_LAST) begin
            state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_n = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_cnt == STOP_LAST) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift[0];
      S_PARITY: tx_d = par;
      default:  tx_d = 1'b1;
    endcase
  end

  assign bus.tx   = tx_d;
  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_r;

endmodule
`default_nettype wire

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter that serialises one DATA_W-bit word per request into an asynchronous frame: start bit, data LSB first, optional parity, then 1 or 2 stop bits. It combines the bit timer, bit counter, shift register and control FSM in a single block, and adds configurable width, parity and stop bits. It sits between the system-side producer (start/data/busy handshake) and the serial line pin.

## Interface
- DATA_W, 8, data bits per frame; legal range 5..9
- CLK_DIV, 16, clk cycles per serial bit; legal range is 2 and above
- PARITY_EN, 0, 1 = append a parity bit after the data bits
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
- STOP_BITS, 1, number of stop bits; legal values 1 or 2
- clk  in  1  system clock
- reset  in  1  one clock; reset is synchronous and active-high
- start  in  1  request to send `data`; sampled only in IDLE
- data  in  DATA_W  word to transmit; captured in the cycle `start` is accepted
- tx  out  1  serial line; idles high
- busy  out  1  high while a frame is in progress
- done  out  1  single-cycle pulse marking frame completion

## Operation
- FSM states:
  - IDLE: tx=1, busy=0.
  - START: tx=0.
  - DATA: tx=shift[0].
  - PARITY: tx=parity bit.
  - STOP: tx=1.
- Transitions:
  - IDLE→START when start=1. The same edge loads data into the shift register, clears the bit timer and bit counter, and computes the parity bit.
  - START→DATA after CLK_DIV cycles.
  - DATA: each bit lasts CLK_DIV cycles. At each bit end the register shifts right and the bit counter increments. After DATA_W bits, go to PARITY if PARITY_EN=1, otherwise go to STOP.
  - PARITY→STOP after CLK_DIV cycles.
  - STOP lasts STOP_BITS×CLK_DIV cycles, then STOP→IDLE. done=1 in the first IDLE cycle.
- Parity bit is XOR of the captured data when PARITY_ODD=0, and ~XOR when PARITY_ODD=1. It is computed from the captured word, so later changes on `data` have no effect.
- Bit timer counts 0..CLK_DIV-1 and is sized $clog2(CLK_DIV). It wraps to 0 at each bit boundary and is held at 0 in IDLE.
- Bit counter is sized $clog2(DATA_W+1) and counts data bits only.
- `start` while busy=1 is ignored. There is no queuing and no error flag.
- `data` is don't-care except in the accept cycle.
- Unused parameter combinations outside the legal ranges are not supported. An elaboration-time assertion must flag them.

## Timing
- Reset values, taking effect at the first clk edge with reset=1: state=IDLE, tx=1, busy=0, done=0, all counters 0.
- Reset mid-frame aborts the frame immediately. tx returns high the next cycle and no done pulse is produced.
- All outputs are registered or decoded from registered state only. No combinational path from start or data to any output.
- Latency: start sampled at edge N means tx=0 and busy=1 from cycle N+1.
- Frame length F = CLK_DIV×(1+DATA_W+PARITY_EN+STOP_BITS) cycles. busy is high for exactly F cycles, then done is high for 1 cycle with busy=0.
- start=1 in the done cycle is accepted, so back-to-back frames have exactly 1 idle-high cycle between them.
- start held high continuously sends consecutive frames, re-capturing data at each accept.
- Simultaneous reset and start: reset wins and the start is dropped.

## Test plan
- Basic frame, DATA_W=8, CLK_DIV=4, no parity, 1 stop, data=0xA5:
  - Required tx (one value per 4-cycle bit): 0, 1,0,1,0,0,1,0,1, 1.
  - busy high for 40 cycles, then one done pulse.
- Parity, PARITY_EN=1, data=0xA5 (four ones):
  - Even parity: parity bit = 0.
  - PARITY_ODD=1: parity bit = 1.
  - data=0x01 with even parity: parity bit = 1.
  - Frame is 44 cycles.
- Config DATA_W=5, STOP_BITS=2, CLK_DIV=3, data=5'h13:
  - Required tx: 0, 1,1,0,0,1, 1, 1, each bit lasting 3 cycles.
  - busy high for 24 cycles.
- Handshake:
  - Pulse start again at mid-frame with data=0xFF: it is ignored and the current frame completes unchanged.
  - Hold start high with data changing between 0x00 and 0xFF: gives two frames separated by exactly 1 idle cycle, each carrying the value present at its accept cycle.
- Reset mid-frame during the DATA state:
  - Next cycle: tx=1, busy=0, done=0.
  - A following start sends a complete, correct frame.
- Data stability:
  - Change data every cycle during a frame: transmitted bits and parity match the word captured at accept.
